// File: rtl/cpu_pkg.sv
// Shared encodings for the 4-bit teaching CPU control unit.
package cpu_pkg;

  // Opcodes (upper 4 bits of the instruction word)
  localparam logic [3:0] OP_ADD_A  = 4'b0000;
  localparam logic [3:0] OP_MOV_AB = 4'b0001;
  localparam logic [3:0] OP_IN_A   = 4'b0010;
  localparam logic [3:0] OP_MOV_AI = 4'b0011;
  localparam logic [3:0] OP_MOV_BA = 4'b0100;
  localparam logic [3:0] OP_ADD_B  = 4'b0101;
  localparam logic [3:0] OP_IN_B   = 4'b0110;
  localparam logic [3:0] OP_MOV_BI = 4'b0111;
  localparam logic [3:0] OP_HALT   = 4'b1000;
  localparam logic [3:0] OP_OUT_B  = 4'b1001;
  localparam logic [3:0] OP_JC     = 4'b1010;
  localparam logic [3:0] OP_OUT_I  = 4'b1011;
  localparam logic [3:0] OP_NOP0   = 4'b1100;
  localparam logic [3:0] OP_NOP1   = 4'b1101;
  localparam logic [3:0] OP_JNC    = 4'b1110;
  localparam logic [3:0] OP_JMP    = 4'b1111;

  // FSM states
  localparam logic [1:0] ST_FETCH  = 2'b00;
  localparam logic [1:0] ST_DECODE = 2'b01;
  localparam logic [1:0] ST_EXEC   = 2'b10;
  localparam logic [1:0] ST_HALT   = 2'b11;

  // ALU source select
  localparam logic [1:0] SEL_A    = 2'b00;
  localparam logic [1:0] SEL_B    = 2'b01;
  localparam logic [1:0] SEL_IN   = 2'b10;
  localparam logic [1:0] SEL_ZERO = 2'b11;

  // Load strobe bit positions
  localparam int LD_A   = 0;
  localparam int LD_B   = 1;
  localparam int LD_OUT = 2;

  // Jump kinds
  localparam logic [1:0] JMP_NONE   = 2'b00;
  localparam logic [1:0] JMP_ALWAYS = 2'b01;
  localparam logic [1:0] JMP_NC     = 2'b10;
  localparam logic [1:0] JMP_C      = 2'b11;

endpackage

// File: rtl/op_decode.sv
// Combinational opcode decoder: source select, load vector, jump kind, halt.
module op_decode
  import cpu_pkg::*;
(
  input  logic [3:0] i_op,
  output logic [1:0] o_sel,
  output logic [2:0] o_load,
  output logic [1:0] o_jmp,
  output logic       o_halt
);

  // Table lookup; NOPs, jumps and HALT load nothing
  always_comb begin
    o_sel  = SEL_ZERO;
    o_load = 3'b000;
    o_jmp  = JMP_NONE;
    o_halt = 1'b0;
    case (i_op)
      OP_ADD_A:  begin o_sel = SEL_A;    o_load[LD_A]   = 1'b1; end
      OP_ADD_B:  begin o_sel = SEL_B;    o_load[LD_B]   = 1'b1; end
      OP_MOV_AI: begin o_sel = SEL_ZERO; o_load[LD_A]   = 1'b1; end
      OP_MOV_BI: begin o_sel = SEL_ZERO; o_load[LD_B]   = 1'b1; end
      OP_MOV_AB: begin o_sel = SEL_B;    o_load[LD_A]   = 1'b1; end
      OP_MOV_BA: begin o_sel = SEL_A;    o_load[LD_B]   = 1'b1; end
      OP_IN_A:   begin o_sel = SEL_IN;   o_load[LD_A]   = 1'b1; end
      OP_IN_B:   begin o_sel = SEL_IN;   o_load[LD_B]   = 1'b1; end
      OP_OUT_B:  begin o_sel = SEL_B;    o_load[LD_OUT] = 1'b1; end
      OP_OUT_I:  begin o_sel = SEL_ZERO; o_load[LD_OUT] = 1'b1; end
      OP_JMP:    o_jmp  = JMP_ALWAYS;
      OP_JNC:    o_jmp  = JMP_NC;
      OP_JC:     o_jmp  = JMP_C;
      OP_HALT:   o_halt = 1'b1;
      default:   ;
    endcase
  end

endmodule

// File: rtl/cpu_control_unit.sv
// Multi-cycle control unit: FETCH/DECODE/EXEC/HALT FSM owning PC, IR and CF.
module cpu_control_unit
  import cpu_pkg::*;
#(
  parameter int              IMM_W    = 4,
  parameter int              PC_W     = 4,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic              in_clk,
  input  logic              in_rst,
  input  logic              in_run,
  input  logic [IMM_W+3:0]  in_instr,
  input  logic              in_alu_carry,
  output logic [PC_W-1:0]   out_pc,
  output logic [IMM_W-1:0]  out_imm,
  output logic [1:0]        out_sel,
  output logic [2:0]        out_load,
  output logic              out_cf,
  output logic              out_halt,
  output logic [1:0]        out_state
);

  logic [1:0]       r_state;
  logic [PC_W-1:0]  r_pc;
  logic [IMM_W+3:0] r_ir;
  logic             r_cf;

  logic [3:0]       w_op;
  logic [IMM_W-1:0] w_imm;
  logic [1:0]       w_sel;
  logic [2:0]       w_load;
  logic [1:0]       w_jmp;
  logic             w_is_halt;
  logic             w_taken;
  logic [PC_W-1:0]  w_target;

  assign w_op  = r_ir[IMM_W+3:IMM_W];
  assign w_imm = r_ir[IMM_W-1:0];

  op_decode u_dec (
    .i_op   (w_op),
    .o_sel  (w_sel),
    .o_load (w_load),
    .o_jmp  (w_jmp),
    .o_halt (w_is_halt)
  );

  // Jump target: immediate zero-extended or truncated to PC width
  generate
    if (PC_W > IMM_W) begin : g_tgt_ext
      assign w_target = {{(PC_W-IMM_W){1'b0}}, w_imm};
    end else begin : g_tgt_trunc
      assign w_target = w_imm[PC_W-1:0];
    end
  endgenerate

  // Branch condition uses CF as it stood before this EXEC
  always_comb begin
    case (w_jmp)
      JMP_ALWAYS: w_taken = 1'b1;
      JMP_NC:     w_taken = ~r_cf;
      JMP_C:      w_taken = r_cf;
      default:    w_taken = 1'b0;
    endcase
  end

  // FSM with PC/IR/CF updates; reset wins in every state
  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      r_state <= ST_FETCH;
      r_pc    <= RESET_PC;
      r_ir    <= '0;
      r_cf    <= 1'b0;
    end else begin
      case (r_state)
        ST_FETCH: if (in_run) begin
          r_ir    <= in_instr;
          r_state <= ST_DECODE;
        end
        ST_DECODE: r_state <= ST_EXEC;
        ST_EXEC: begin
          if (w_is_halt) begin
            r_state <= ST_HALT;
          end else begin
            r_pc    <= w_taken ? w_target : r_pc + PC_W'(1);
            r_cf    <= in_alu_carry;
            r_state <= ST_FETCH;
          end
        end
        default: ; // HALT is sticky until reset
      endcase
    end
  end

  assign out_pc    = r_pc;
  assign out_imm   = w_imm;
  assign out_sel   = w_sel;
  assign out_load  = (r_state == ST_EXEC) ? w_load : 3'b000;
  assign out_cf    = r_cf;
  assign out_halt  = (r_state == ST_HALT);
  assign out_state = r_state;

endmodule

// File: tb/tb_cpu_control_unit.sv
// Randomized self-checking bench for cpu_control_unit with an opcode-table model.
module tb_cpu_control_unit;

  logic       clk = 0;
  logic       rst, run, carry;
  logic [7:0] instr;
  logic [3:0] pc, imm;
  logic [1:0] sel, state;
  logic [2:0] load;
  logic       cf, halt;

  int n_pass = 0, n_total = 0;
  int m_pc;   // model PC
  int m_cf;   // model carry flag

  always #5 clk = ~clk;

  cpu_control_unit #(.IMM_W(4), .PC_W(4), .RESET_PC(4'd0)) dut (
    .in_clk(clk), .in_rst(rst), .in_run(run), .in_instr(instr),
    .in_alu_carry(carry), .out_pc(pc), .out_imm(imm), .out_sel(sel),
    .out_load(load), .out_cf(cf), .out_halt(halt), .out_state(state)
  );

  // Reference table: expected sel and load (A=1, B=2, OUT=4) per opcode
  function automatic logic [4:0] ref_ctl(input int op);
    case (op)
      0:  return {2'd0, 3'd1};
      5:  return {2'd1, 3'd2};
      3:  return {2'd3, 3'd1};
      7:  return {2'd3, 3'd2};
      1:  return {2'd1, 3'd1};
      4:  return {2'd0, 3'd2};
      2:  return {2'd2, 3'd1};
      6:  return {2'd2, 3'd2};
      9:  return {2'd1, 3'd4};
      11: return {2'd3, 3'd4};
      default: return {2'd3, 3'd0};
    endcase
  endfunction

  task automatic do_reset();
    rst = 1; run = 0; carry = 0; instr = 0;
    repeat (2) @(negedge clk);
    rst = 0;
    m_pc = 0; m_cf = 0;
  endtask

  // Run one instruction through FETCH/DECODE/EXEC, checking each phase against the model
  task automatic exec_instr(input int op, input int im, input int c, input string tag);
    logic [4:0] ctl;
    int taken, nxt_pc, nxt_cf, nxt_st;
    ctl = ref_ctl(op);
    run = 1; instr = 8'(op * 16 + im); carry = c[0];
    @(negedge clk);
    n_total++;
    if ({state, load, sel, imm} !== {2'd1, 3'd0, ctl[4:3], 4'(im)})
      $display("FAIL %s decode: state=%0d load=%b sel=%0d imm=%0d, need state=1 load=000 sel=%0d imm=%0d",
               tag, state, load, sel, imm, ctl[4:3], im);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if ({state, load, sel, imm} !== {2'd2, ctl[2:0], ctl[4:3], 4'(im)})
      $display("FAIL %s exec: state=%0d load=%b sel=%0d imm=%0d, need state=2 load=%b sel=%0d imm=%0d",
               tag, state, load, sel, imm, ctl[2:0], ctl[4:3], im);
    else n_pass++;
    taken = (op == 15) || (op == 14 && m_cf == 0) || (op == 10 && m_cf == 1);
    if (op == 8) begin
      nxt_pc = m_pc; nxt_cf = m_cf; nxt_st = 3;
    end else begin
      nxt_pc = taken ? im : (m_pc + 1) % 16;
      nxt_cf = c; nxt_st = 0;
    end
    @(negedge clk);
    n_total++;
    if ({pc, cf, state, load, halt} !== {4'(nxt_pc), nxt_cf[0], 2'(nxt_st), 3'd0, (nxt_st == 3)})
      $display("FAIL %s after: pc=%0d cf=%0d state=%0d load=%b halt=%0d, need pc=%0d cf=%0d state=%0d load=000",
               tag, pc, cf, state, load, halt, nxt_pc, nxt_cf, nxt_st);
    else n_pass++;
    m_pc = nxt_pc; m_cf = nxt_cf;
  endtask

  task automatic test_reset();
    do_reset();
    n_total++;
    if ({pc, cf, load, halt, state, sel, imm} !== {4'd0, 1'b0, 3'd0, 1'b0, 2'd0, 2'd0, 4'd0})
      $display("FAIL reset: pc=%0d cf=%0d load=%b halt=%0d state=%0d sel=%0d imm=%0d, need all zero",
               pc, cf, load, halt, state, sel, imm);
    else n_pass++;
  endtask

  task automatic test_mov();
    do_reset();
    exec_instr(3, 3, 0, "mov_a3");
  endtask

  task automatic test_carry_jumps();
    do_reset();
    exec_instr(0, 1, 1, "add_a1");   // CF -> 1
    exec_instr(14, 5, 1, "jnc5");    // not taken, PC=2
    exec_instr(10, 9, 0, "jc9");     // taken on old CF, PC=9, CF=0
    exec_instr(14, 12, 0, "jnc12");  // taken now CF=0
  endtask

  task automatic test_wrap_stall();
    logic [3:0] hold_pc;
    do_reset();
    exec_instr(15, 15, 0, "jmp15");
    exec_instr(12, 0, 0, "nop_wrap");  // 15 -> 0
    exec_instr(13, 7, 1, "nop1");
    run = 0; hold_pc = pc;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_total++;
      if ({state, load, pc} !== {2'd0, 3'd0, 4'(m_pc)})
        $display("FAIL stall%0d: state=%0d load=%b pc=%0d, need state=0 load=000 pc=%0d",
                 i, state, load, pc, m_pc);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    int op;
    do_reset();
    for (int i = 0; i < 40; i++) begin
      do op = $urandom_range(0, 15); while (op == 8);
      exec_instr(op, $urandom_range(0, 15), $urandom_range(0, 1), "rand");
    end
  endtask

  task automatic test_halt();
    do_reset();
    for (int i = 0; i < 3; i++) exec_instr(12, 0, 1, "pre_halt");
    exec_instr(8, 0, 0, "halt");
    for (int i = 0; i < 10; i++) begin
      instr = 8'($urandom_range(0, 255)); carry = $urandom_range(0, 1);
      @(negedge clk);
      n_total++;
      if ({halt, pc, cf, load, state} !== {1'b1, 4'd3, 1'b1, 3'd0, 2'd3})
        $display("FAIL halt_hold%0d: halt=%0d pc=%0d cf=%0d load=%b state=%0d, need halt=1 pc=3 cf=1 load=000 state=3",
                 i, halt, pc, cf, load, state);
      else n_pass++;
    end
    rst = 1; @(negedge clk); rst = 0;
    n_total++;
    if ({halt, pc, state} !== {1'b0, 4'd0, 2'd0})
      $display("FAIL halt_reset: halt=%0d pc=%0d state=%0d, need halt=0 pc=0 state=0", halt, pc, state);
    else n_pass++;
  endtask

  task automatic test_reset_exec();
    do_reset();
    exec_instr(0, 2, 1, "pre_rst_add");  // PC=1, CF=1
    run = 1; instr = 8'h54; carry = 1;
    repeat (2) @(negedge clk);
    n_total++;
    if ({state, load} !== {2'd2, 3'b010})
      $display("FAIL rst_exec_strobe: state=%0d load=%b, need state=2 load=010", state, load);
    else n_pass++;
    rst = 1; run = 0;
    @(negedge clk);
    rst = 0;
    n_total++;
    if ({load, pc, cf, state} !== {3'd0, 4'd0, 1'b0, 2'd0})
      $display("FAIL rst_exec_after: load=%b pc=%0d cf=%0d state=%0d, need load=000 pc=0 cf=0 state=0",
               load, pc, cf, state);
    else n_pass++;
  endtask

  initial begin
    rst = 1; run = 0; carry = 0; instr = 0;
    test_reset();
    test_mov();
    test_carry_jumps();
    test_wrap_stall();
    test_random();
    test_halt();
    test_reset_exec();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
